// File: rtl/lpc_frame_scheduler.sv
// Ping-pong framer: fills FRAME_LEN-sample banks and kicks the LPC encoder on each full bank.
// Optional macro LPC_SCHED_DROP_EN: real-time mode, samples arriving during STALL are discarded.
module lpc_frame_scheduler #(
  parameter int FRAME_LEN = 160,
  parameter int ADDR_W    = 8,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              enc_start,
  output logic              enc_bank,
  input  logic              enc_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              overrun,
  input  logic              overrun_clr
);

  typedef enum logic [0:0] {FILL, STALL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t state_reg;
  logic   busy_reg;
  logic   accept;
  logic   drop;
  logic   done_eff;
  logic   swap;

  // A done pulse only counts while an encode is actually running, and never
  // in the cycle its own start pulse is being issued.
  assign done_eff = enc_done & busy_reg & ~enc_start;

  always_comb begin
    sample_ready = 1'b0;
    drop         = 1'b0;
    if (!reset) begin
      case (state_reg)
        FILL:  sample_ready = enable;
        STALL: begin
`ifdef LPC_SCHED_DROP_EN
          sample_ready = enable;
          drop         = 1'b1;
`else
          sample_ready = 1'b0;
`endif
        end
        default: sample_ready = 1'b0;
      endcase
    end
  end

  assign accept = sample_valid & sample_ready;
  assign wr_en  = accept & ~drop;

  always_comb begin
    swap = 1'b0;
    if (!reset) begin
      if (state_reg == FILL)
        swap = wr_en && (wr_addr == LAST_ADDR) && (!busy_reg || done_eff);
      else
        swap = done_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FILL;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      enc_start   <= 1'b0;
      enc_bank    <= 1'b0;
      busy_reg    <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      enc_start <= 1'b0;

      if (enc_start)
        busy_reg <= 1'b1;
      else if (enc_done)
        busy_reg <= 1'b0;

      // Set has priority over clear so a simultaneous clear cannot hide a loss.
      if (sample_valid && state_reg == STALL)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      case (state_reg)
        FILL: begin
          if (wr_en) begin
            if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              if (!swap)
                state_reg <= STALL;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        STALL: begin
          wr_addr <= '0;
          if (swap)
            state_reg <= FILL;
        end
        default: state_reg <= FILL;
      endcase

      if (swap) begin
        enc_start   <= 1'b1;
        enc_bank    <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// Directed bench for lpc_frame_scheduler with FRAME_LEN=4; follows LPC_SCHED_DROP_EN when defined.
module tb_lpc_frame_scheduler;

  localparam int FRAME_LEN = 4;
  localparam int ADDR_W    = 2;
  localparam int FCNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              enc_start;
  logic              enc_bank;
  logic              enc_done = 1'b0;
  logic [FCNT_W-1:0] frame_count;
  logic              overrun;
  logic              overrun_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  lpc_frame_scheduler #(
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W(ADDR_W),
    .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .wr_en(wr_en),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .enc_start(enc_start),
    .enc_bank(enc_bank),
    .enc_done(enc_done),
    .frame_count(frame_count),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("  ok   %s = %0d", tag, got);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; checks then follow before the next rise.
  task automatic cyc(input logic r, input logic v, input logic d, input logic c, input logic en);
    @(negedge clk);
    reset = r; sample_valid = v; enc_done = d; overrun_clr = c; enable = en;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_ready", sample_ready, 0);
    check("rst_wr_en", wr_en, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // 1: first frame, with an enable=0 hold in the middle
    $display("-- scenario 1: first frame");
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s1_rst_wr_addr", wr_addr, 0);
    check("s1_rst_fcnt", frame_count, 0);
    check("s1_rst_overrun", overrun, 0);
    check("s1_rst_enc_start", enc_start, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_dis_ready", sample_ready, 0);
        check("s1_dis_wr_en", wr_en, 0);
        check("s1_dis_wr_addr", wr_addr, 2);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("s1_wr_en", wr_en, 1);
      check("s1_wr_addr", wr_addr, k);
      check("s1_wr_bank", wr_bank, 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s1_enc_start", enc_start, 1);
    check("s1_enc_bank", enc_bank, 0);
    check("s1_wr_bank", wr_bank, 1);
    check("s1_fcnt", frame_count, 1);
    check("s1_wr_addr0", wr_addr, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s1_start_pulse", enc_start, 0);

    // 2: encoder finishes mid-frame, no stall
    $display("-- scenario 2: done after sample 6");
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, (k == 6), 1'b0, 1'b1);
      check("s2_wr_en", wr_en, 1);
      check("s2_wr_addr", wr_addr, k % 4);
      if (k == 4) check("s2_first_start", enc_start, 1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s2_enc_start", enc_start, 1);
    check("s2_enc_bank", enc_bank, 1);
    check("s2_wr_bank", wr_bank, 0);
    check("s2_fcnt", frame_count, 2);
    check("s2_overrun", overrun, 0);

    // 3/4: encoder still busy when second bank fills
    $display("-- scenario 3: stall");
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("s3_wr_en", wr_en, 1);
    end
`ifndef LPC_SCHED_DROP_EN
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("s3_stall_ready", sample_ready, 0);
    check("s3_stall_wr_en", wr_en, 0);
    check("s3_stall_wr_addr", wr_addr, 0);
    check("s3_stall_wr_bank", wr_bank, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("s3_overrun", overrun, 1);
    check("s3_done_ready", sample_ready, 0);
    check("s3_done_wr_en", wr_en, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("s4_drop_ready", sample_ready, 1);
      check("s4_drop_wr_en", wr_en, 0);
      check("s4_drop_wr_addr", wr_addr, 0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("s4_overrun", overrun, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    check("s3_enc_start", enc_start, 1);
    check("s3_enc_bank", enc_bank, 1);
    check("s3_ready", sample_ready, 1);
    check("s3_wr_en", wr_en, 1);
    check("s3_wr_bank", wr_bank, 0);
    check("s3_wr_addr", wr_addr, 0);
    check("s3_fcnt", frame_count, 2);
    check("s3_set_wins", overrun, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("s3_clr_cycle", overrun, 1);
    check("s3_next_addr", wr_addr, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s3_cleared", overrun, 0);

    // 5: done in the same cycle as the last sample of the second bank
    $display("-- scenario 5: done with last sample");
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, (k == 7), 1'b0, 1'b1);
      check("s5_wr_en", wr_en, 1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s5_enc_start", enc_start, 1);
    check("s5_enc_bank", enc_bank, 1);
    check("s5_ready", sample_ready, 1);
    check("s5_overrun", overrun, 0);
    check("s5_fcnt", frame_count, 2);

    // 6: reset in the middle of a frame with overrun set
    $display("-- scenario 6: mid-frame reset");
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s6_pre_wr_addr", wr_addr, 2);
    check("s6_pre_overrun", overrun, 1);
    check("s6_pre_fcnt", frame_count, 2);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s6_wr_addr", wr_addr, 0);
    check("s6_wr_bank", wr_bank, 0);
    check("s6_fcnt", frame_count, 0);
    check("s6_overrun", overrun, 0);
    check("s6_enc_start", enc_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
